// File: rtl/scale_unit_arbiter_if.sv
// Request/response bundle between the solver iteration engines and the shared
// 1/aNN scaling unit. The engines use the master side; the arbiter uses the slave side.
interface scale_unit_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [37*NREQ-1:0]   req_x;
  logic [16*NREQ-1:0]   req_ann;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [36:0]          resp_x;

  modport master (
    output req_valid, req_x, req_ann, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_x
  );

  modport slave (
    input  req_valid, req_x, req_ann, resp_ready,
    output req_ready, resp_valid, resp_id, resp_x
  );
endinterface

// File: rtl/scale_unit_arbiter.sv
// Round-robin shared X*(1/aNN) scaler: input clamp stage, then multiply/clamp output stage.
// Define SCALE_SAT_STAT_EN to build the saturation event counter on sat_cnt.
module scale_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  scale_unit_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [15:0]          sat_cnt
);

  function automatic logic [31:0] sat_in(input logic [36:0] x);
    if (!x[36] && (x[35:31] != 5'b00000))      sat_in = 32'h7FFF_FFFF;
    else if (x[36] && (x[35:31] != 5'b11111))  sat_in = 32'h8000_0000;
    else                                       sat_in = {x[36], x[30:0]};
  endfunction

  function automatic logic [31:0] sat_out(input logic [47:0] p);
    if (!p[47] && (p[46:45] != 2'b00))      sat_out = 32'h7FFF_FFFF;
    else if (p[47] && (p[46:45] != 2'b11))  sat_out = 32'h8000_0000;
    else                                    sat_out = {p[47], p[44:14]};
  endfunction

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [IDW-1:0]     s1_id_q, s1_id_d;
  logic [31:0]        s1_x_q, s1_x_d;
  logic [15:0]        s1_ann_q, s1_ann_d;
  logic               s2_valid_q, s2_valid_d;
  logic [IDW-1:0]     s2_id_q, s2_id_d;
  logic [31:0]        s2_x_q, s2_x_d;

  logic               s2_adv, s1_adv, found, xfer;
  int                 win, scan_idx;
  logic [36:0]        win_x;
  logic [15:0]        win_ann;
  logic signed [47:0] xs_ext, ann_ext, prod;
  logic [31:0]        prod_sat;

  assign s2_adv = !s2_valid_q || bus.resp_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    found    = 1'b0;
    win      = 0;
    scan_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req_valid[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
    win_x         = bus.req_x[37*win +: 37];
    win_ann       = bus.req_ann[16*win +: 16];
    xfer          = found && s1_adv && !rst;
    bus.req_ready = '0;
    if (xfer) bus.req_ready[win] = 1'b1;
  end

  assign xs_ext   = {{16{s1_x_q[31]}}, s1_x_q};
  assign ann_ext  = {{32{s1_ann_q[15]}}, s1_ann_q};
  assign prod     = xs_ext * ann_ext;
  assign prod_sat = sat_out(prod);

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_x_d     = s1_x_q;
    s1_ann_d   = s1_ann_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_x_d     = s2_x_q;
    if (xfer) ptr_d = IDW'(win);
    if (s1_adv) begin
      s1_valid_d = xfer;
      if (xfer) begin
        s1_id_d  = IDW'(win);
        s1_x_d   = sat_in(win_x);
        s1_ann_d = win_ann;
      end
    end
    // Output register only reloads with real data, so a stalled result stays put.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_id_d = s1_id_q;
        s2_x_d  = prod_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= IDW'(NREQ - 1);
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_x_q     <= '0;
      s1_ann_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_x_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_x_q     <= s1_x_d;
      s1_ann_q   <= s1_ann_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_x_q     <= s2_x_d;
    end
  end

  assign bus.resp_valid = s2_valid_q;
  assign bus.resp_id    = s2_id_q;
  assign bus.resp_x     = {5'b00000, s2_x_q};
  assign busy           = s1_valid_q || s2_valid_q;

`ifdef SCALE_SAT_STAT_EN
  function automatic logic in_clamped(input logic [36:0] x);
    in_clamped = (!x[36] && (x[35:31] != 5'b00000)) || (x[36] && (x[35:31] != 5'b11111));
  endfunction

  function automatic logic out_clamped(input logic [47:0] p);
    out_clamped = (!p[47] && (p[46:45] != 2'b00)) || (p[47] && (p[46:45] != 2'b11));
  endfunction

  logic        s1_sat_q, s1_sat_d;
  logic        s2_sat_q, s2_sat_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // The saturation flag rides alongside its item; counting happens at handshake.
  always_comb begin
    s1_sat_d  = s1_adv ? (xfer && in_clamped(win_x)) : s1_sat_q;
    s2_sat_d  = s2_adv ? (s1_valid_q && (s1_sat_q || out_clamped(prod))) : s2_sat_q;
    sat_cnt_d = sat_cnt_q;
    if (s2_valid_q && bus.resp_ready && s2_sat_q && (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sat_q  <= 1'b0;
      s2_sat_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      s1_sat_q  <= s1_sat_d;
      s2_sat_q  <= s2_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_scale_unit_arbiter.sv
// Directed bench for scale_unit_arbiter: scaling/saturation vectors, round-robin order,
// backpressure hold and reset flush. Counter expectations follow SCALE_SAT_STAT_EN.
module tb_scale_unit_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef SCALE_SAT_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] sat_cnt;
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_sat = 0;

  scale_unit_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  scale_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .sat_cnt (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_x = '0;
    bus.req_ann = '0;
    bus.resp_ready = 1'b1;
    tick();
    tick();
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    vectors++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid_busy: got %b%b expected 00", bus.resp_valid, busy); end
    vectors++;
    if (bus.resp_x !== 37'h0 || bus.resp_id !== 2'd0 || sat_cnt !== 16'h0) begin
      miscompares++; $display("[TB] FAIL reset_data: got x=%h id=%0d cnt=%h expected all zero", bus.resp_x, bus.resp_id, sat_cnt);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[37*i +: 37] = 37'((i + 1) * 256);
      bus.req_ann[16*i +: 16] = 16'h4000;
    end
    bus.resp_ready = 1'b1;
    bus.req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) bus.req_valid = '0;
      #1;
      if (c < 8) begin
        vectors++;
        if (bus.req_ready !== 4'(1 << (c % 4))) begin miscompares++; $display("[TB] FAIL rr_grant c%0d: got %b expected %b", c, bus.req_ready, 4'(1 << (c % 4))); end
      end
      if (c >= 2) begin
        vectors++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'((c - 2) % 4) || bus.resp_x !== 37'((((c - 2) % 4) + 1) * 256)) begin
          miscompares++;
          $display("[TB] FAIL rr_resp c%0d: got v=%b id=%0d x=%h expected v=1 id=%0d x=%h", c, bus.resp_valid, bus.resp_id, bus.resp_x,
                   (c - 2) % 4, 37'((((c - 2) % 4) + 1) * 256));
        end
      end
      tick();
    end
    vectors++;
    if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_drain: got busy=%b v=%b expected 0 0", busy, bus.resp_valid); end
  endtask

  task automatic send_one(input int id, input logic [36:0] x, input logic [15:0] ann, input logic [36:0] exp_x, input bit sat);
    bus.req_x = '0;
    bus.req_ann = '0;
    bus.req_x[37*id +: 37] = x;
    bus.req_ann[16*id +: 16] = ann;
    bus.resp_ready = 1'b1;
    bus.req_valid = 4'(1 << id);
    #1;
    vectors++;
    if (bus.req_ready !== 4'(1 << id)) begin miscompares++; $display("[TB] FAIL send_ready id%0d: got %b expected %b", id, bus.req_ready, 4'(1 << id)); end
    tick();
    bus.req_valid = '0;
    vectors++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL send_stage1 id%0d: got v=%b busy=%b expected 0 1", id, bus.resp_valid, busy); end
    tick();
    vectors++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(id) || bus.resp_x !== exp_x) begin
      miscompares++;
      $display("[TB] FAIL send_resp x=%h ann=%h: got v=%b id=%0d x=%h expected v=1 id=%0d x=%h", x, ann, bus.resp_valid, bus.resp_id, bus.resp_x, id, exp_x);
    end
    if (sat && STAT) exp_sat++;
    tick();
    vectors++;
    if (sat_cnt !== 16'(exp_sat) || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL send_cnt x=%h: got cnt=%0d busy=%b expected cnt=%0d busy=0", x, sat_cnt, busy, exp_sat);
    end
  endtask

  task automatic test_scaling();
    send_one(0, 37'h00_0001_0000, 16'h4000, 37'h00_0001_0000, 1'b0);
    send_one(0, 37'h00_0001_0000, 16'h2000, 37'h00_0000_8000, 1'b0);
    send_one(2, 37'h1F_FFFF_FFFF, 16'h4000, 37'h00_FFFF_FFFF, 1'b0);
    send_one(3, 37'h1F_FFFF_FF00, 16'h2000, 37'h00_FFFF_FF80, 1'b0);
    send_one(1, 37'h00_FFFF_FFFF, 16'h7FFF, 37'h00_7FFF_FFFF, 1'b1);
    send_one(1, 37'h10_0000_0000, 16'h4000, 37'h00_8000_0000, 1'b1);
    send_one(2, 37'h00_7FFF_FFFF, 16'h8000, 37'h00_8000_0000, 1'b1);
  endtask

  task automatic test_backpressure();
    bus.req_x = '0;
    bus.req_ann = '0;
    bus.req_ann[48 +: 16] = 16'h4000;
    bus.req_x[111 +: 37] = 37'h111;
    bus.resp_ready = 1'b0;
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (bus.req_ready !== ((c < 2) ? 4'b1000 : 4'b0000)) begin
        miscompares++; $display("[TB] FAIL bp_ready c%0d: got %b expected %b", c, bus.req_ready, (c < 2) ? 4'b1000 : 4'b0000);
      end
      if (c >= 2) begin
        vectors++;
        if (bus.resp_valid !== 1'b1 || bus.resp_x !== 37'h111 || bus.resp_id !== 2'd3) begin
          miscompares++; $display("[TB] FAIL bp_hold c%0d: got v=%b id=%0d x=%h expected v=1 id=3 x=111", c, bus.resp_valid, bus.resp_id, bus.resp_x);
        end
      end
      tick();
      if (c == 0) bus.req_x[111 +: 37] = 37'h222;
      if (c == 1) bus.req_x[111 +: 37] = 37'h333;
    end
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    #1;
    vectors++;
    if (bus.resp_valid !== 1'b1 || bus.resp_x !== 37'h111) begin miscompares++; $display("[TB] FAIL bp_drain0: got v=%b x=%h expected v=1 x=111", bus.resp_valid, bus.resp_x); end
    tick();
    vectors++;
    if (bus.resp_valid !== 1'b1 || bus.resp_x !== 37'h222) begin miscompares++; $display("[TB] FAIL bp_drain1: got v=%b x=%h expected v=1 x=222", bus.resp_valid, bus.resp_x); end
    tick();
    vectors++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_empty: got v=%b busy=%b expected 0 0", bus.resp_valid, busy); end
  endtask

  task automatic test_reset_flush();
    bus.req_x = '0;
    bus.req_ann = '0;
    bus.req_x[111 +: 37] = 37'h00_FFFF_FFFF;
    bus.req_ann[48 +: 16] = 16'h7FFF;
    bus.resp_ready = 1'b0;
    bus.req_valid = 4'b1000;
    tick();
    tick();
    vectors++;
    if (busy !== 1'b1 || bus.resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_full: got busy=%b v=%b expected 1 1", busy, bus.resp_valid); end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL flush_ready_in_rst: got %b expected 0000", bus.req_ready); end
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    vectors++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0 || sat_cnt !== 16'h0 || bus.resp_x !== 37'h0) begin
      miscompares++; $display("[TB] FAIL flush_cleared: got v=%b busy=%b cnt=%h x=%h expected all zero", bus.resp_valid, busy, sat_cnt, bus.resp_x);
    end
    bus.req_x[0 +: 37] = 37'h5;
    bus.req_ann[0 +: 16] = 16'h4000;
    bus.resp_ready = 1'b1;
    bus.req_valid = 4'b1001;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL flush_priority: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    vectors++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_x !== 37'h5) begin
      miscompares++; $display("[TB] FAIL flush_first_resp: got v=%b id=%0d x=%h expected v=1 id=0 x=5", bus.resp_valid, bus.resp_id, bus.resp_x);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_scaling();
    test_backpressure();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
